// File: rtl/rv32i_types.sv
// Shared core types: branch queue entry layout and redirect sequencer definitions.
package rv32i_types;

    localparam int NUM_ROB_ENTRIES_BITS  = 4;
    localparam int REDIRECT_FLUSH_CYCLES = 2;

    typedef struct packed {
        logic [NUM_ROB_ENTRIES_BITS-1:0] rob_idx;
        logic [31:0]                     branch_pc;
    } brq_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } redirect_state_t;

endpackage

// File: rtl/branch_redirect.sv
// Commit-side mispredict recovery: capture target, hold flush, then offer a
// redirect PC to fetch over valid/ready while counting mispredicts.
module branch_redirect
    import rv32i_types::*;
#(
    parameter int FLUSH_CYCLES = REDIRECT_FLUSH_CYCLES,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            mispredict,
    input  brq_entry_t                      br_PC,
    input  logic                            redirect_ready,
    output logic                            redirect_valid,
    output logic [31:0]                     redirect_pc,
    output logic [NUM_ROB_ENTRIES_BITS-1:0] redirect_rob_idx,
    output logic                            flush,
    output logic                            fetch_stall,
    output logic [CNT_WIDTH-1:0]            mispredict_count
);

    redirect_state_t                 state_q, state_d;
    logic [31:0]                     target_q;
    logic [NUM_ROB_ENTRIES_BITS-1:0] rob_q;
    logic [3:0]                      flush_cnt_q;
    logic [CNT_WIDTH-1:0]            count_q;

    // A mispredict always restarts the flush, overriding any pending handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (mispredict) state_d = FLUSH;
            FLUSH:    if (mispredict) state_d = FLUSH;
                      else if (flush_cnt_q == 4'd0) state_d = REDIRECT;
            REDIRECT: if (mispredict) state_d = FLUSH;
                      else if (redirect_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            rob_q       <= '0;
            flush_cnt_q <= '0;
            count_q     <= '0;
        end else begin
            state_q <= state_d;
            if (mispredict) begin
                target_q    <= br_PC.branch_pc;
                rob_q       <= br_PC.rob_idx;
                flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                if (count_q != '1)
                    count_q <= count_q + CNT_WIDTH'(1);
            end else if (state_q == FLUSH && flush_cnt_q != 4'd0) begin
                flush_cnt_q <= flush_cnt_q - 4'd1;
            end
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign flush            = (state_q == FLUSH);
    assign redirect_valid   = (state_q == REDIRECT);
    assign fetch_stall      = (state_q != IDLE);
    assign redirect_pc      = target_q;
    assign redirect_rob_idx = rob_q;
    assign mispredict_count = count_q;

    assert property (@(posedge clk) disable iff (rst) mispredict |-> !$isunknown(br_PC))
        else $error("branch_redirect: br_PC contains X while mispredict is high");

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: latency, backpressure, preemption, reset, saturation.
module tb_branch_redirect;
    import rv32i_types::*;

    localparam int FC = 2;
    localparam int CW = 4;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            mispredict;
    brq_entry_t                      br_PC;
    logic                            redirect_ready;
    logic                            redirect_valid;
    logic [31:0]                     redirect_pc;
    logic [NUM_ROB_ENTRIES_BITS-1:0] redirect_rob_idx;
    logic                            flush;
    logic                            fetch_stall;
    logic [CW-1:0]                   mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_redirect #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .mispredict       (mispredict),
        .br_PC            (br_PC),
        .redirect_ready   (redirect_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_rob_idx (redirect_rob_idx),
        .flush            (flush),
        .fetch_stall      (fetch_stall),
        .mispredict_count (mispredict_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mp(input logic [31:0] pc, input logic [3:0] idx);
        mispredict       = 1'b1;
        br_PC.branch_pc  = pc;
        br_PC.rob_idx    = idx;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic f, input logic s);
        chk({tag, "_valid"}, 64'(redirect_valid), 64'(v));
        chk({tag, "_flush"}, 64'(flush), 64'(f));
        chk({tag, "_stall"}, 64'(fetch_stall), 64'(s));
    endtask

    initial begin
        rst = 1'b1; mispredict = 1'b0; br_PC = '0; redirect_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_out("rst", 1'b0, 1'b0, 1'b0);
        chk("rst_pc", 64'(redirect_pc), 64'h0);
        chk("rst_cnt", 64'(mispredict_count), 64'h0);

        // 1: single mispredict, ready tied high
        redirect_ready = 1'b1;
        mp(32'h1040, 4'd3);
        tick(); chk_out("s1_c6", 1'b0, 1'b1, 1'b1);
        mispredict = 1'b0;
        tick(); chk_out("s1_c7", 1'b0, 1'b1, 1'b1);
        tick(); chk_out("s1_c8", 1'b1, 1'b0, 1'b1);
        chk("s1_pc", 64'(redirect_pc), 64'h1040);
        chk("s1_rob", 64'(redirect_rob_idx), 64'd3);
        chk("s1_cnt", 64'(mispredict_count), 64'd1);
        tick(); chk_out("s1_c9", 1'b0, 1'b0, 1'b0);

        // 2: backpressure until cycle 12
        redirect_ready = 1'b0;
        mp(32'h1040, 4'd3);
        tick(); mispredict = 1'b0;
        tick();
        tick(); chk_out("s2_c8", 1'b1, 1'b0, 1'b1);
        for (int i = 9; i <= 12; i++) begin
            tick();
            chk($sformatf("s2_c%0d_valid", i), 64'(redirect_valid), 64'd1);
            chk($sformatf("s2_c%0d_pc", i), 64'(redirect_pc), 64'h1040);
        end
        redirect_ready = 1'b1;
        tick(); chk_out("s2_c13", 1'b0, 1'b0, 1'b0);
        chk("s2_cnt", 64'(mispredict_count), 64'd2);

        // 3: second mispredict during FLUSH
        mp(32'h1040, 4'd1);
        tick(); chk_out("s3_c6", 1'b0, 1'b1, 1'b1);
        mp(32'h2000, 4'd2);
        tick(); chk_out("s3_c7", 1'b0, 1'b1, 1'b1);
        mispredict = 1'b0;
        tick(); chk_out("s3_c8", 1'b0, 1'b1, 1'b1);
        tick(); chk_out("s3_c9", 1'b1, 1'b0, 1'b1);
        chk("s3_pc", 64'(redirect_pc), 64'h2000);
        chk("s3_rob", 64'(redirect_rob_idx), 64'd2);
        chk("s3_cnt", 64'(mispredict_count), 64'd4);
        tick(); chk_out("s3_c10", 1'b0, 1'b0, 1'b0);

        // 4: mispredict coincides with ready in REDIRECT
        redirect_ready = 1'b0;
        mp(32'h3000, 4'd4);
        tick(); mispredict = 1'b0;
        tick();
        tick(); chk_out("s4_redir", 1'b1, 1'b0, 1'b1);
        chk("s4_pc0", 64'(redirect_pc), 64'h3000);
        redirect_ready = 1'b1;
        mp(32'h4000, 4'd5);
        tick(); chk_out("s4_pre", 1'b0, 1'b1, 1'b1);
        chk("s4_cnt", 64'(mispredict_count), 64'd6);
        mispredict = 1'b0;
        tick(); chk_out("s4_f2", 1'b0, 1'b1, 1'b1);
        tick(); chk_out("s4_redir2", 1'b1, 1'b0, 1'b1);
        chk("s4_pc1", 64'(redirect_pc), 64'h4000);
        chk("s4_rob1", 64'(redirect_rob_idx), 64'd5);
        tick(); chk_out("s4_done", 1'b0, 1'b0, 1'b0);

        // 5: reset in FLUSH together with mispredict
        mp(32'h5000, 4'd6);
        tick(); chk_out("s5_flush", 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        mp(32'h6000, 4'd7);
        tick(); chk_out("s5_rst", 1'b0, 1'b0, 1'b0);
        chk("s5_pc", 64'(redirect_pc), 64'h0);
        chk("s5_rob", 64'(redirect_rob_idx), 64'h0);
        chk("s5_cnt", 64'(mispredict_count), 64'h0);
        rst = 1'b0; mispredict = 1'b0;
        tick(); chk_out("s5_idle", 1'b0, 1'b0, 1'b0);

        // 6: counter saturation over 17 sequences
        redirect_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            mp(32'h100 * i, 4'(i));
            tick(); mispredict = 1'b0;
            tick(); tick(); tick();
            chk($sformatf("s6_cnt%0d", i), 64'(mispredict_count), 64'((i > 15) ? 15 : i));
        end
        chk_out("s6_idle", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_redirect.md
# branch_redirect

Commit-side recovery sequencer that sits directly downstream of the branch queue. On a commit-time mispredict it captures the resolved branch target from the branch queue's `br_PC` output and holds fetch stalled while the back end flushes. It then presents a redirect PC to fetch with a valid/ready handshake and keeps per-core mispredict statistics.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is held high after a capture; legal range 1..15.
- `CNT_WIDTH`, default 32: width of `mispredict_count`.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset. Synchronous and active-high.
- `mispredict`, input, 1: commit-time mispredict pulse, shared with the branch queue.
- `br_PC`, input, `brq_entry_t`: the branch queue's mispredicted entry (`rob_idx`, `branch_pc`). Valid only in a cycle where `mispredict`=1.
- `redirect_ready`, input, 1: fetch accepts the redirect.
- `redirect_valid`, output, 1: redirect PC offered to fetch.
- `redirect_pc`, output, 32: target PC.
- `redirect_rob_idx`, output, `NUM_ROB_ENTRIES_BITS`: `rob_idx` of the captured branch, for debug and trace.
- `flush`, output, 1: back-end flush strobe to the ROB, reservation stations and RAT checkpoint restore.
- `fetch_stall`, output, 1: fetch must not issue.
- `mispredict_count`, output, `CNT_WIDTH`: saturating count of captures.

## Operation
The block is a three-state FSM: IDLE, FLUSH, REDIRECT.

- **IDLE**
  - All outputs are 0, except `redirect_pc`, `redirect_rob_idx` and `mispredict_count`, which hold their last values.
  - `mispredict`=1 captures `br_PC.branch_pc` into `target` and `br_PC.rob_idx` into `rob_q`.
  - It then loads `flush_cnt` with `FLUSH_CYCLES-1` and moves to FLUSH.
- **FLUSH**
  - `flush`=1 and `fetch_stall`=1.
  - `flush_cnt` decrements each cycle.
  - When `flush_cnt`==0, the FSM moves to REDIRECT.
- **REDIRECT**
  - `redirect_valid`=1, with `redirect_pc`=`target` and `redirect_rob_idx`=`rob_q`.
  - `fetch_stall`=1.
  - The redirect holds stable until `redirect_ready`=1 at a rising edge. That edge completes the handshake and the FSM returns to IDLE.
- **Counter:** `mispredict_count` increments on every capture and saturates at all-ones.
- **Mispredict in FLUSH or REDIRECT:**
  - The new `br_PC` is recaptured, `flush_cnt` is reloaded and the FSM goes to FLUSH. The counter increments.
  - A pending redirect is dropped without a handshake, even if `redirect_ready`=1 in the same cycle.
- **Mispredict in the same cycle as `redirect_ready` in REDIRECT:** the mispredict wins; the FSM goes to FLUSH with the new target.
- **Debug check:** `br_PC` containing X while `mispredict`=1 is a simulation assertion failure.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- **Reset:**
  - `rst`=1 at an edge forces IDLE.
  - It clears `target`, `rob_q`, `flush_cnt` and `mispredict_count` to 0.
  - All outputs are 0 in the following cycle.
  - `rst` overrides a coincident `mispredict`, and a reset in any state abandons the sequence.
- **Capture latency:**
  - `mispredict` sampled at edge N gives `flush`=1 and `fetch_stall`=1 during cycle N+1.
  - `flush` is high for exactly `FLUSH_CYCLES` cycles, N+1 .. N+`FLUSH_CYCLES`.
  - `redirect_valid` first rises in cycle N+`FLUSH_CYCLES`+1.
- **Handshake completion:** `redirect_ready` sampled high while `redirect_valid`=1 at edge M gives `redirect_valid`=0 and `fetch_stall`=0 in cycle M+1.
- **Back-to-back mispredicts:** the minimum spacing between mispredict-triggered redirects is `FLUSH_CYCLES`+1 cycles.
- **`fetch_stall`:** equals (state != IDLE).
- **`flush_cnt` width:** 4 bits.

## Structure
- Package `rv32i_types` provides `brq_entry_t` and `NUM_ROB_ENTRIES_BITS`.
- Add the following to `rv32i_types`:
  - `redirect_state_t`, an enum with IDLE, FLUSH, REDIRECT.
  - The constant `REDIRECT_FLUSH_CYCLES`.
- The block is a single module with no sub-module. The FSM, the counters and the capture registers all live in one `always_ff`, with a small `always_comb` for next-state logic.

## Test plan
1. **Single mispredict, no backpressure.**
   - Stimulus: `FLUSH_CYCLES`=2; `mispredict` in cycle 5 with `branch_pc`=0x0000_1040 and `rob_idx`=3; `redirect_ready` tied to 1.
   - Required: `flush`=1 in cycles 6 and 7; `redirect_valid`=1 in cycle 8 only, with `redirect_pc`=0x1040; `mispredict_count`=1.
2. **Backpressure.**
   - Stimulus: same as scenario 1, with `redirect_ready` held low until cycle 12.
   - Required: `redirect_valid` and `redirect_pc`=0x1040 stay stable in cycles 8..12; IDLE in cycle 13.
3. **Second mispredict during FLUSH.**
   - Stimulus: a capture of 0x1040 in cycle 5, then a second mispredict with 0x2000 in cycle 6.
   - Required: `flush` is high in cycles 6..8; the only redirect presented has `redirect_pc`=0x2000; `mispredict_count`=2.
4. **Mispredict coinciding with `redirect_ready` in REDIRECT.**
   - Required: the handshake is not completed and the FSM enters FLUSH with the new target.
5. **Reset mid-operation.**
   - Stimulus: `rst` asserted in a FLUSH cycle together with `mispredict`.
   - Required: all outputs 0 next cycle; `mispredict_count`=0.
6. **Saturation.**
   - Stimulus: `CNT_WIDTH`=4; 17 sequences.
   - Required: `mispredict_count` stops at 15.
